// File: rtl/spi_dev_master.sv
// spi_dev_master: SPI mode-0 master for the shared device-handler bus.
// Three device slots are encoded onto {ncs2,ncs1}. Words arrive on a
// valid/ready stream, are shifted out MSB first, and each received word is
// returned with a one-cycle rx_valid strobe.
module spi_dev_master #(
  parameter int unsigned DW      = 8,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    dev_sel,
  input  logic [DW-1:0] tx_data,
  input  logic          tx_last,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic [DW-1:0] rx_data,
  output logic          rx_valid,
  output logic          err,
  output logic          busy,
  output logic          sclk,
  output logic          mosi,
  input  logic          miso,
  output logic          ncs1,
  output logic          ncs2
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BW = $clog2(DW);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(DW - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_HIGH, S_LOW, S_WAIT, S_HOLD, S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          sclk_q, sclk_d;
  logic [1:0]    cs_q, cs_d;          // {ncs2, ncs1}
  logic          mosi_q, mosi_d;
  logic [DW-2:0] data_q, data_d;      // bits still to send below the current one
  logic          last_q, last_d;
  logic [DW-1:0] rx_shift_q, rx_shift_d;
  logic [DW-1:0] rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          err_q, err_d;
  logic          cnt_end;
  logic          accept;

  // State register: every flop of the block, asynchronous active-high reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      sclk_q     <= 1'b0;
      cs_q       <= '1;
      mosi_q     <= 1'b1;
      data_q     <= '0;
      last_q     <= 1'b0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      sclk_q     <= sclk_d;
      cs_q       <= cs_d;
      mosi_q     <= mosi_d;
      data_q     <= data_d;
      last_q     <= last_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic: phase sequencing, shifting and word hand-off
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    sclk_d     = sclk_q;
    cs_d       = cs_q;
    mosi_d     = mosi_q;
    data_d     = data_q;
    last_d     = last_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (dev_sel == 2'd0) begin
            err_d = 1'b1;
          end else begin
            cs_d    = dev_sel - 2'd1;
            data_d  = tx_data[DW-2:0];
            mosi_d  = tx_data[DW-1];
            last_d  = tx_last;
            cnt_d   = '0;
            bit_d   = '0;
            state_d = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        if (cnt_end) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          state_d = S_HIGH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HIGH: begin
        if (cnt_q == '0) begin
          rx_shift_d = (rx_shift_q << 1) | {{(DW-1){1'b0}}, miso};
        end
        if (cnt_end) begin
          cnt_d   = '0;
          sclk_d  = 1'b0;
          state_d = S_LOW;
          // mosi changes on the falling edge; the final bit hands the word up instead
          if (bit_q == BIT_MAX) begin
            rx_data_d  = rx_shift_d;
            rx_valid_d = 1'b1;
          end else begin
            mosi_d = data_q[DW-2];
            data_d = data_q << 1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LOW: begin
        if (cnt_end) begin
          cnt_d = '0;
          if (bit_q != BIT_MAX) begin
            bit_d   = bit_q + BW'(1);
            sclk_d  = 1'b1;
            state_d = S_HIGH;
          end else if (last_q) begin
            state_d = S_HOLD;
          end else if (accept) begin
            // Streaming word: skip SETUP so the inter-word gap is one LOW phase
            data_d  = tx_data[DW-2:0];
            mosi_d  = tx_data[DW-1];
            last_d  = tx_last;
            bit_d   = '0;
            sclk_d  = 1'b1;
            state_d = S_HIGH;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT: begin
        if (accept) begin
          data_d  = tx_data[DW-2:0];
          mosi_d  = tx_data[DW-1];
          last_d  = tx_last;
          bit_d   = '0;
          cnt_d   = '0;
          state_d = S_SETUP;
        end
      end
      S_HOLD: begin
        if (cnt_end) begin
          cnt_d   = '0;
          cs_d    = '1;
          mosi_d  = 1'b1;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_end) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: handshake and status decoded from registered state
  always_comb begin
    cnt_end  = (cnt_q == CNT_MAX);
    tx_ready = (state_q == S_IDLE) || (state_q == S_WAIT) ||
               ((state_q == S_LOW) && cnt_end && (bit_q == BIT_MAX) && !last_q);
    accept   = tx_valid && tx_ready;
    busy     = !(cs_q[0] && cs_q[1]);
  end

  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign ncs1     = cs_q[0];
  assign ncs2     = cs_q[1];
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign err      = err_q;

endmodule

// File: tb/tb_spi_dev_master.sv
// tb_spi_dev_master: directed tests of spi_dev_master in two configurations
// (DW=8/CLK_DIV=2 and DW=16/CLK_DIV=1).
module tb_spi_dev_master;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  dev_sel;
  logic [15:0] tx_data;
  logic        tx_last;
  logic        tx_valid;
  logic        use_b;
  int          miso_mode;   // 0: loopback to mosi, 1: tied low

  logic       tx_ready_a, rx_valid_a, err_a, busy_a, sclk_a, mosi_a, miso_a, ncs1_a, ncs2_a;
  logic [7:0] rx_data_a;
  logic        tx_ready_b, rx_valid_b, err_b, busy_b, sclk_b, mosi_b, miso_b, ncs1_b, ncs2_b;
  logic [15:0] rx_data_b;
  logic [15:0] slv_sh;
  logic        sclk_pb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign miso_a = (miso_mode == 0) ? mosi_a : 1'b0;
  assign miso_b = slv_sh[15];

  spi_dev_master #(.DW(8), .CLK_DIV(2)) u_a (
    .clk(clk), .reset(rst), .dev_sel(dev_sel), .tx_data(tx_data[7:0]),
    .tx_last(tx_last), .tx_valid(tx_valid & ~use_b), .tx_ready(tx_ready_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .err(err_a), .busy(busy_a),
    .sclk(sclk_a), .mosi(mosi_a), .miso(miso_a), .ncs1(ncs1_a), .ncs2(ncs2_a)
  );

  spi_dev_master #(.DW(16), .CLK_DIV(1)) u_b (
    .clk(clk), .reset(rst), .dev_sel(dev_sel), .tx_data(tx_data),
    .tx_last(tx_last), .tx_valid(tx_valid & use_b), .tx_ready(tx_ready_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .err(err_b), .busy(busy_b),
    .sclk(sclk_b), .mosi(mosi_b), .miso(miso_b), .ncs1(ncs1_b), .ncs2(ncs2_b)
  );

  // Slot-1 device model for u_b: presents 0x1234 MSB first, shifts on sclk fall
  always @(negedge clk) begin
    if (ncs1_b) slv_sh <= 16'h1234;
    else if (sclk_pb && !sclk_b) slv_sh <= {slv_sh[14:0], 1'b1};
    sclk_pb <= sclk_b;
  end

  // Signals of whichever instance is under test
  logic        m_tx_ready, m_rx_valid, m_err, m_sclk, m_ncs1, m_ncs2;
  logic [15:0] m_rx_data;
  assign m_tx_ready = use_b ? tx_ready_b : tx_ready_a;
  assign m_rx_valid = use_b ? rx_valid_b : rx_valid_a;
  assign m_err      = use_b ? err_b : err_a;
  assign m_sclk     = use_b ? sclk_b : sclk_a;
  assign m_ncs1     = use_b ? ncs1_b : ncs1_a;
  assign m_ncs2     = use_b ? ncs2_b : ncs2_a;
  assign m_rx_data  = use_b ? rx_data_b : {8'h00, rx_data_a};

  // Frame measurements
  int          cs_low, rises, hi_min, hi_max, lo_min, lo_max, rxv, errs, toggles, gap, enc_chg;
  logic [1:0]  enc_first;
  logic [15:0] rx_hist [4];

  task automatic push(input logic [1:0] sel, input logic [15:0] d, input logic l,
                      output logic ok);
    int n;
    dev_sel = sel; tx_data = d; tx_last = l; tx_valid = 1'b1; ok = 1'b0; n = 0;
    while (!m_tx_ready && n < 400) begin @(negedge clk); n++; end
    if (m_tx_ready) begin @(posedge clk); #1; ok = 1'b1; end
    tx_valid = 1'b0;
  endtask

  task automatic measure(input int max_cyc);
    logic [1:0] cs, prev_cs;
    logic prev_sclk, started, done, in_lo;
    int hi_run, lo_run, rx_n;
    cs_low = 0; rises = 0; hi_min = 999; hi_max = 0; lo_min = 999; lo_max = 0;
    rxv = 0; errs = 0; toggles = 0; gap = 0; enc_chg = 0; enc_first = 2'b11;
    for (int k = 0; k < 4; k++) rx_hist[k] = 16'hxxxx;
    prev_cs = {m_ncs2, m_ncs1}; prev_sclk = m_sclk;
    started = 0; done = 0; in_lo = 0; hi_run = 0; lo_run = 0; rx_n = 0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(negedge clk);
      cs = {m_ncs2, m_ncs1};
      if (cs != prev_cs) toggles++;
      if (m_sclk != prev_sclk) toggles++;
      if (cs != 2'b11) begin
        cs_low++; started = 1;
        if (enc_first == 2'b11) enc_first = cs;
        else if (cs != enc_first) enc_chg++;
      end else begin
        in_lo = 0;
      end
      if (m_sclk) begin
        if (!prev_sclk) begin
          rises++;
          if (in_lo) begin
            if (lo_run < lo_min) lo_min = lo_run;
            if (lo_run > lo_max) lo_max = lo_run;
          end
          in_lo = 0; hi_run = 0;
        end
        hi_run++;
      end else begin
        if (prev_sclk) begin
          if (hi_run < hi_min) hi_min = hi_run;
          if (hi_run > hi_max) hi_max = hi_run;
          in_lo = 1; lo_run = 0;
        end
        if (in_lo) lo_run++;
      end
      if (m_rx_valid) begin
        rxv++;
        if (rx_n < 4) begin rx_hist[rx_n] = m_rx_data; rx_n++; end
      end
      if (m_err) errs++;
      if (started && cs == 2'b11 && !m_tx_ready) gap++;
      if (started && cs == 2'b11 && m_tx_ready) done = 1;
      prev_cs = cs; prev_sclk = m_sclk;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (sclk_a !== 1'b0) begin errors++; $display("FAIL rst_sclk got %b want 0", sclk_a); end
    checks++; if ({ncs2_a, ncs1_a} !== 2'b11) begin errors++; $display("FAIL rst_cs got %b want 11", {ncs2_a, ncs1_a}); end
    checks++; if (mosi_a !== 1'b1) begin errors++; $display("FAIL rst_mosi got %b want 1", mosi_a); end
    checks++; if (rx_data_a !== 8'h00) begin errors++; $display("FAIL rst_rx_data got %h want 00", rx_data_a); end
    checks++; if ({rx_valid_a, err_a, busy_a} !== 3'b000) begin errors++; $display("FAIL rst_strobes got %b want 000", {rx_valid_a, err_a, busy_a}); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (tx_ready_a !== 1'b1) begin errors++; $display("FAIL rst_tx_ready got %b want 1", tx_ready_a); end
  endtask

  task automatic test_reset_midframe;
    logic ok;
    int n;
    use_b = 0; miso_mode = 0;
    push(2'd2, 16'h00FF, 1'b1, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL mid_accept got %b want 1", ok); end
    n = 0;
    while (!sclk_a && n < 20) begin @(negedge clk); n++; end
    checks++; if (sclk_a !== 1'b1) begin errors++; $display("FAIL mid_reach_high got %b want 1", sclk_a); end
    rst = 1'b1;
    #1;
    checks++; if ({ncs2_a, ncs1_a} !== 2'b11) begin errors++; $display("FAIL mid_cs got %b want 11", {ncs2_a, ncs1_a}); end
    checks++; if (sclk_a !== 1'b0) begin errors++; $display("FAIL mid_sclk got %b want 0", sclk_a); end
    checks++; if (mosi_a !== 1'b1) begin errors++; $display("FAIL mid_mosi got %b want 1", mosi_a); end
    @(negedge clk);
    rst = 1'b0;
    measure(30);
    checks++; if (rxv !== 0) begin errors++; $display("FAIL mid_no_rx got %0d want 0", rxv); end
    checks++; if (cs_low !== 0) begin errors++; $display("FAIL mid_cs_idle got %0d want 0", cs_low); end
    checks++; if (tx_ready_a !== 1'b1) begin errors++; $display("FAIL mid_tx_ready got %b want 1", tx_ready_a); end
  endtask

  task automatic test_single_word;
    logic ok;
    use_b = 0; miso_mode = 0;
    fork
      push(2'd1, 16'h00A5, 1'b1, ok);
      measure(200);
    join
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL sw_accept got %b want 1", ok); end
    checks++; if (cs_low !== 36) begin errors++; $display("FAIL sw_cs_low got %0d want 36", cs_low); end
    checks++; if (enc_first !== 2'b00 || enc_chg !== 0) begin errors++; $display("FAIL sw_enc got %b/%0d want 00/0", enc_first, enc_chg); end
    checks++; if (rises !== 8) begin errors++; $display("FAIL sw_pulses got %0d want 8", rises); end
    checks++; if (hi_min !== 2 || hi_max !== 2) begin errors++; $display("FAIL sw_high got %0d..%0d want 2..2", hi_min, hi_max); end
    checks++; if (lo_min !== 2 || lo_max !== 2) begin errors++; $display("FAIL sw_low got %0d..%0d want 2..2", lo_min, lo_max); end
    checks++; if (rxv !== 1) begin errors++; $display("FAIL sw_rxv got %0d want 1", rxv); end
    checks++; if (rx_hist[0] !== 16'h00A5) begin errors++; $display("FAIL sw_rx_data got %h want 00a5", rx_hist[0]); end
    checks++; if (gap !== 2) begin errors++; $display("FAIL sw_gap got %0d want 2", gap); end
  endtask

  task automatic test_back_to_back;
    logic ok1, ok2;
    use_b = 0; miso_mode = 1;
    fork
      begin
        push(2'd2, 16'h003C, 1'b0, ok1);
        push(2'd2, 16'h00F0, 1'b1, ok2);
      end
      measure(300);
    join
    checks++; if ({ok1, ok2} !== 2'b11) begin errors++; $display("FAIL b2b_accept got %b want 11", {ok1, ok2}); end
    checks++; if (enc_first !== 2'b01 || enc_chg !== 0) begin errors++; $display("FAIL b2b_enc got %b/%0d want 01/0", enc_first, enc_chg); end
    checks++; if (cs_low !== 68) begin errors++; $display("FAIL b2b_cs_low got %0d want 68", cs_low); end
    checks++; if (rises !== 16) begin errors++; $display("FAIL b2b_pulses got %0d want 16", rises); end
    checks++; if (lo_min !== 2 || lo_max !== 2) begin errors++; $display("FAIL b2b_low got %0d..%0d want 2..2", lo_min, lo_max); end
    checks++; if (rxv !== 2) begin errors++; $display("FAIL b2b_rxv got %0d want 2", rxv); end
    checks++; if (rx_hist[0] !== 16'h0000 || rx_hist[1] !== 16'h0000) begin errors++; $display("FAIL b2b_rx_data got %h,%h want 0000,0000", rx_hist[0], rx_hist[1]); end
  endtask

  task automatic test_stall;
    logic ok1, ok2;
    int n, stall_bad, setup_cyc;
    use_b = 0; miso_mode = 0; stall_bad = 0; setup_cyc = 0;
    fork
      begin
        push(2'd3, 16'h0081, 1'b0, ok1);
        n = 0;
        while (!tx_ready_a && n < 200) begin @(negedge clk); n++; end
        @(negedge clk);
        dev_sel = 2'd1;
        repeat (20) begin
          if (sclk_a || {ncs2_a, ncs1_a} != 2'b10 || !tx_ready_a) stall_bad++;
          @(negedge clk);
        end
        push(2'd1, 16'h007E, 1'b1, ok2);
        @(negedge clk);
        while (!sclk_a && setup_cyc < 20) begin setup_cyc++; @(negedge clk); end
      end
      measure(400);
    join
    checks++; if ({ok1, ok2} !== 2'b11) begin errors++; $display("FAIL stall_accept got %b want 11", {ok1, ok2}); end
    checks++; if (stall_bad !== 0) begin errors++; $display("FAIL stall_bus got %0d bad cycles want 0", stall_bad); end
    checks++; if (setup_cyc !== 2) begin errors++; $display("FAIL stall_setup got %0d want 2", setup_cyc); end
    checks++; if (enc_first !== 2'b10 || enc_chg !== 0) begin errors++; $display("FAIL stall_enc got %b/%0d want 10/0", enc_first, enc_chg); end
    checks++; if (rises !== 16) begin errors++; $display("FAIL stall_pulses got %0d want 16", rises); end
    checks++; if (rxv !== 2) begin errors++; $display("FAIL stall_rxv got %0d want 2", rxv); end
    checks++; if (rx_hist[0] !== 16'h0081 || rx_hist[1] !== 16'h007E) begin errors++; $display("FAIL stall_rx_data got %h,%h want 0081,007e", rx_hist[0], rx_hist[1]); end
  endtask

  task automatic test_bad_sel;
    logic ok;
    use_b = 0; miso_mode = 0;
    push(2'd0, 16'h0099, 1'b1, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL err_accept got %b want 1", ok); end
    measure(12);
    checks++; if (errs !== 1) begin errors++; $display("FAIL err_pulse got %0d cycles want 1", errs); end
    checks++; if (toggles !== 0 || cs_low !== 0) begin errors++; $display("FAIL err_bus got %0d toggles %0d cs want 0 0", toggles, cs_low); end
    fork
      push(2'd1, 16'h005A, 1'b1, ok);
      measure(200);
    join
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL err_next_accept got %b want 1", ok); end
    checks++; if (enc_first !== 2'b00 || cs_low !== 36) begin errors++; $display("FAIL err_next_cs got %b/%0d want 00/36", enc_first, cs_low); end
    checks++; if (rxv !== 1 || rx_hist[0] !== 16'h005A) begin errors++; $display("FAIL err_next_rx got %0d/%h want 1/005a", rxv, rx_hist[0]); end
  endtask

  task automatic test_wide_fast;
    logic ok;
    use_b = 1;
    fork
      push(2'd1, 16'hC3C3, 1'b1, ok);
      measure(200);
    join
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL w16_accept got %b want 1", ok); end
    checks++; if (cs_low !== 34) begin errors++; $display("FAIL w16_cs_low got %0d want 34", cs_low); end
    checks++; if (rises !== 16) begin errors++; $display("FAIL w16_pulses got %0d want 16", rises); end
    checks++; if (hi_min !== 1 || hi_max !== 1 || lo_min !== 1 || lo_max !== 1) begin errors++; $display("FAIL w16_widths got hi %0d..%0d lo %0d..%0d want 1", hi_min, hi_max, lo_min, lo_max); end
    checks++; if (rxv !== 1 || rx_hist[0] !== 16'h1234) begin errors++; $display("FAIL w16_rx got %0d/%h want 1/1234", rxv, rx_hist[0]); end
    checks++; if (gap !== 1) begin errors++; $display("FAIL w16_gap got %0d want 1", gap); end
    use_b = 0;
  endtask

  initial begin
    tx_valid = 1'b0; tx_last = 1'b0; tx_data = '0; dev_sel = 2'd0;
    use_b = 1'b0; miso_mode = 0;
    test_reset;
    test_reset_midframe;
    test_single_word;
    test_back_to_back;
    test_stall;
    test_bad_sel;
    test_wide_fast;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
